// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory port between fetch and data requesters
// Each granted access runs to completion or timeout; data wins ties unless fetch has lost MAX_D_STREAK in a row.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_D_STREAK   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_done,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [1:0]            owner
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  own_d_q, own_d_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [SW-1:0]         streak_q, streak_d;

  logic grant_d, grant_i, busy, resp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      own_d_q  <= 1'b0;
      tcnt_q   <= '0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      own_d_q  <= own_d_d;
      tcnt_q   <= tcnt_d;
      streak_q <= streak_d;
    end
  end

  // Fetch is forced to win only when it is contending and data has used up its streak.
  assign grant_d = d_req && !(if_req && (streak_q == SW'(MAX_D_STREAK)));
  assign grant_i = if_req && !grant_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    own_d_d  = own_d_q;
    tcnt_d   = tcnt_q;
    streak_d = streak_q;
    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          state_d = S_BUSY_D;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          own_d_d = 1'b1;
          tcnt_d  = '0;
          if (if_req) streak_d = streak_q + 1'b1;
        end else if (grant_i) begin
          state_d  = S_BUSY_I;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          own_d_d  = 1'b0;
          tcnt_d   = '0;
          streak_d = '0;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (mem_ready) begin
          rdata_d = we_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_BUSY_I) || (state_q == S_BUSY_D);
  assign resp      = (state_q == S_RESP);
  assign mem_req   = busy;
  assign mem_we    = (state_q == S_BUSY_D) && we_q;
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;
  assign if_done   = resp && !own_d_q;
  assign d_done    = resp && own_d_q;
  assign if_rdata  = if_done ? rdata_q : '0;
  assign d_rdata   = d_done ? rdata_q : '0;
  assign if_err    = if_done && err_q;
  assign d_err     = d_done && err_q;

  always_comb begin
    owner = 2'b00;
    case (state_q)
      S_BUSY_I: owner = 2'b01;
      S_BUSY_D: owner = 2'b10;
      S_RESP:   owner = own_d_q ? 2'b10 : 2'b01;
      default:  owner = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
// Transaction-level model: arbitration from request/streak rules, results from the memory responder's choices.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int MS = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic          if_done, if_err, d_done, d_err, mem_req, mem_we;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    owner;

  int n_chk = 0;
  int n_fail = 0;
  int m_streak = 0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .MAX_D_STREAK(MS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_owner"}, owner, 2'b00);
    chk({tag, "_dones"}, {if_done, d_done}, 2'b00);
  endtask

  // Runs one access from the IDLE cycle: lat<0 means memory never answers.
  task automatic do_txn(input int lat, input logic [DW-1:0] rd, output logic [1:0] first_owner);
    bit            exp_d, exp_we, fin, to;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rd;
    int            c, nreq;
    exp_d = d_req && !(if_req && m_streak == MS);
    if (exp_d) begin
      exp_addr = d_addr; exp_we = d_we; exp_wdata = d_wdata;
      if (if_req) m_streak++;
    end else begin
      exp_addr = if_addr; exp_we = 1'b0; exp_wdata = '0;
      m_streak = 0;
    end
    step();
    first_owner = owner;
    c = 0; nreq = 0; fin = 0; to = 0;
    while (!fin) begin
      if (mem_req) nreq++;
      chk("busy_addr", mem_addr, exp_addr);
      chk("busy_we", mem_we, exp_we);
      if (exp_d) chk("busy_wdata", mem_wdata, exp_wdata);
      chk("busy_owner", owner, exp_d ? 2'b10 : 2'b01);
      chk("busy_no_done", {if_done, d_done}, 2'b00);
      if (exp_d) begin d_addr = $urandom; d_wdata = $urandom; end
      else if_addr = $urandom;
      mem_rdata = $urandom;
      if (lat >= 0 && c == lat) begin
        mem_ready = 1'b1; mem_rdata = rd; fin = 1;
      end else if (c == TO - 1) begin
        to = 1; fin = 1;
      end
      step();
      mem_ready = 1'b0;
      c++;
    end
    chk("mem_req_cycles", nreq, to ? TO : lat + 1);
    exp_rd = (to || exp_we) ? '0 : rd;
    chk("resp_mem_req", mem_req, 1'b0);
    chk("resp_owner", owner, exp_d ? 2'b10 : 2'b01);
    chk("resp_if_done", if_done, !exp_d);
    chk("resp_d_done", d_done, exp_d);
    if (exp_d) begin
      chk("d_rdata", d_rdata, exp_rd);
      chk("d_err", d_err, to);
    end else begin
      chk("if_rdata", if_rdata, exp_rd);
      chk("if_err", if_err, to);
    end
    step();
    chk_quiet("idle");
  endtask

  initial begin
    logic [1:0] fo;
    logic [9:0] pat;
    bit         if_pend, d_pend, win_d;
    #2;
    chk("rst_outs0", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
    chk("rst_outs1", {if_done, if_err, d_done, d_err, owner}, '0);
    chk("rst_rdata", {if_rdata, d_rdata}, '0);
    step(); step();
    reset = 1'b1;
    step();
    chk_quiet("post_rst");

    // fetch read at 0x100
    if_req = 1'b1; if_addr = 32'h100;
    do_txn(0, 32'h00A00093, fo);
    if_req = 1'b0;
    // store with three wait cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF;
    do_txn(3, 32'h12345678, fo);
    // load that never completes
    d_we = 1'b0; d_addr = 32'h204;
    do_txn(-1, 32'h0, fo);
    // permanent contention
    pat = 10'b1111011110;
    for (int i = 0; i < 10; i++) begin
      if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      d_addr = $urandom; if_addr = $urandom;
      do_txn($urandom_range(0, 2), $urandom, fo);
      chk("tie_order", fo, pat[9-i] ? 2'b10 : 2'b01);
    end
    // back-to-back fetches 0x0 then 0x4
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h0;
    do_txn(0, 32'hAAAA0000, fo);
    if_addr = 32'h4;
    do_txn(1, 32'hBBBB0004, fo);
    if_req = 1'b0;

    // random traffic
    if_pend = 0; d_pend = 0;
    for (int t = 0; t < 300; t++) begin
      if (!if_pend && ($urandom_range(0, 1) == 1)) begin
        if_pend = 1; if_addr = $urandom;
      end
      if (!d_pend && ($urandom_range(0, 1) == 1)) begin
        d_pend = 1; d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1);
      end
      if_req = if_pend; d_req = d_pend;
      if (!if_pend && !d_pend) begin
        step();
        chk_quiet("rand_idle");
        continue;
      end
      win_d = d_pend && !(if_pend && m_streak == MS);
      do_txn(($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 5)), $urandom, fo);
      if (win_d) begin d_pend = 0; d_req = 1'b0; end
      else begin if_pend = 0; if_req = 1'b0; end
    end
    if_req = 1'b0; d_req = 1'b0;

    // asynchronous reset in the middle of a data access
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hCAFEF00D;
    step();
    chk("pre_rst_mem_req", mem_req, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("arst_outs0", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
    chk("arst_outs1", {if_done, if_err, d_done, d_err, owner}, '0);
    d_req = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_quiet("after_arst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
